// File: rtl/key_debounce_multi.sv
// N-key active-low button front end: 2-FF sync, per-key debounce, press/release pulses,
// lowest-index key code, long-press detect; define KEY_REPEAT_EN to enable auto-repeat.
module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int DEB_CNT    = 500000,
  parameter int LONG_CNT   = 50000000,
  parameter int REPEAT_CNT = 10000000,
  localparam int CODE_W    = $clog2(N_KEYS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [CODE_W-1:0] key_val,
  output logic [CODE_W-1:0] key_long
);

  localparam int DEB_W    = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

`ifdef KEY_REPEAT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LATCHED = 2'd2, S_REPEAT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LATCHED = 2'd2} state_t;
`endif

  logic [N_KEYS-1:0] r_sync1, r_sync2, r_stable;
  logic [DEB_W-1:0]  r_deb_cnt [N_KEYS];
  logic [N_KEYS-1:0] r_key_state, r_press, r_release;
  logic [N_KEYS-1:0] w_fall, w_rise;
  logic [CODE_W-1:0] w_press_code;
  logic              w_owner_rel;

  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
  logic [CODE_W-1:0] r_owner, w_owner_nxt;
  logic [CODE_W-1:0] r_key_val, w_key_val_nxt;
  logic [CODE_W-1:0] r_key_long, w_key_long_nxt;
  logic              w_long_tc, w_rep_tc;

  // Stable level is active-low like the pins; it only follows sync after DEB_CNT mismatched clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      for (int i = 0; i < N_KEYS; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_KEYS; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CNT - 1)) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign w_fall = ~r_stable & ~r_key_state;
  assign w_rise =  r_stable &  r_key_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_state <= '0;
      r_press     <= '0;
      r_release   <= '0;
    end else begin
      r_key_state <= ~r_stable;
      r_press     <= w_fall;
      r_release   <= w_rise;
    end
  end

  always_comb begin
    w_press_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_fall[i]) w_press_code = CODE_W'(i + 1);
    end
  end

  always_comb begin
    w_owner_rel = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (r_owner == CODE_W'(i + 1)) w_owner_rel = w_rise[i];
    end
  end

  assign w_long_tc = (r_cnt == HOLD_W'(LONG_CNT - 1));
  assign w_rep_tc  = (r_cnt == HOLD_W'(REPEAT_CNT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_owner    <= '0;
      r_key_val  <= '0;
      r_key_long <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_key_val  <= w_key_val_nxt;
      r_key_long <= w_key_long_nxt;
    end
  end

  // A fresh press always takes ownership, whatever state the hold logic is in.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    if (w_press_code != '0) begin
      w_owner_nxt = w_press_code;
      w_cnt_nxt   = '0;
      w_state_nxt = S_HELD;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
        end
        S_HELD: begin
          if (w_owner_rel) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_owner_nxt = '0;
          end else if (w_long_tc) begin
            w_cnt_nxt   = '0;
`ifdef KEY_REPEAT_EN
            w_state_nxt = S_REPEAT;
`else
            w_state_nxt = S_LATCHED;
`endif
          end else begin
            w_cnt_nxt = r_cnt + HOLD_W'(1);
          end
        end
        S_LATCHED: begin
          if (w_owner_rel) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_owner_nxt = '0;
          end
        end
`ifdef KEY_REPEAT_EN
        S_REPEAT: begin
          if (w_owner_rel) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_owner_nxt = '0;
          end else if (w_rep_tc) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + HOLD_W'(1);
          end
        end
`endif
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_owner_nxt = '0;
        end
      endcase
    end
  end

  // Press code beats a same-cycle repeat; owner release suppresses long/repeat pulses.
  always_comb begin
    w_key_val_nxt  = w_press_code;
    w_key_long_nxt = '0;
    if ((w_press_code == '0) && !w_owner_rel) begin
      if ((r_state == S_HELD) && w_long_tc) w_key_long_nxt = r_owner;
`ifdef KEY_REPEAT_EN
      if ((r_state == S_REPEAT) && w_rep_tc) w_key_val_nxt = r_owner;
`endif
    end
  end

  assign key_state   = r_key_state;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_val     = r_key_val;
  assign key_long    = r_key_long;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: expected events queued with their cycle, popped as outputs pulse.
module tb_key_debounce_multi;
  localparam int NK  = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_in = 4'hF;
  logic [NK-1:0] key_state, key_press, key_release;
  logic [CW-1:0] key_val, key_long;

  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [CW-1:0] val;
    logic [CW-1:0] lng;
  } ev_t;

  ev_t sb[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;

  key_debounce_multi #(
    .N_KEYS(NK), .DEB_CNT(DEB), .LONG_CNT(LNG), .REPEAT_CNT(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_val(key_val), .key_long(key_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r,
                           input logic [CW-1:0] v, input logic [CW-1:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.val = v; e.lng = l;
    sb.push_back(e);
  endtask

  // One clock: count the rising edge, then inspect outputs on the falling edge.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (|{key_press, key_release, key_val, key_long}) begin
      chk("unexpected_event", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ev_cycle",   cyc,         e.cyc);
        chk("ev_press",   key_press,   e.press);
        chk("ev_release", key_release, e.rel);
        chk("ev_val",     key_val,     e.val);
        chk("ev_long",    key_long,    e.lng);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"},   key_state,   '0);
    chk({tag, "_press"},   key_press,   '0);
    chk({tag, "_release"}, key_release, '0);
    chk({tag, "_val"},     key_val,     '0);
    chk({tag, "_long"},    key_long,    '0);
  endtask

  initial begin
    int c;
    int p;
    #1;
    chk_idle_outputs("in_reset");
    ticks(2);
    rst = 1'b1;
    ticks(2);
    chk_idle_outputs("post_reset");

    // 3-clock glitch on key 2 must be absorbed
    key_in[2] = 1'b0;
    ticks(3);
    key_in[2] = 1'b1;
    ticks(10);
    chk("glitch_state", key_state, 4'b0000);

    // single press of key 1, released before long-press
    c = cyc;
    key_in = 4'b1101;
    expect_ev(c + 7, 4'b0010, 4'b0000, 3'd2, 3'd0);
    expect_ev(c + 17, 4'b0000, 4'b0010, 3'd0, 3'd0);
    ticks(6);
    chk("k1_state_early", key_state, 4'b0000);
    ticks(4);
    chk("k1_state_held", key_state, 4'b0010);
    key_in = 4'hF;
    ticks(12);
    chk("k1_state_rel", key_state, 4'b0000);

    // simultaneous press of keys 0 and 3
    c = cyc;
    key_in = 4'b0110;
    expect_ev(c + 7, 4'b1001, 4'b0000, 3'd1, 3'd0);
    expect_ev(c + 17, 4'b0000, 4'b1001, 3'd0, 3'd0);
    ticks(10);
    chk("k03_state", key_state, 4'b1001);
    key_in = 4'hF;
    ticks(12);

    // key 2 held 40 clocks past its press: long press, then repeats if enabled
    c = cyc;
    p = c + 7;
    key_in = 4'b1011;
    expect_ev(p, 4'b0100, 4'b0000, 3'd3, 3'd0);
    expect_ev(p + LNG, 4'b0000, 4'b0000, 3'd0, 3'd3);
`ifdef KEY_REPEAT_EN
    expect_ev(p + LNG + REP, 4'b0000, 4'b0000, 3'd3, 3'd0);
    expect_ev(p + LNG + 2 * REP, 4'b0000, 4'b0000, 3'd3, 3'd0);
`endif
    expect_ev(p + 40, 4'b0000, 4'b0100, 3'd0, 3'd0);
    ticks(40);
    chk("k2_state_long", key_state, 4'b0100);
    key_in = 4'hF;
    ticks(12);

    // key 0 held past long press, then key 3 pressed: ownership moves to code 4
    c = cyc;
    p = c + 7;
    key_in = 4'b1110;
    expect_ev(p, 4'b0001, 4'b0000, 3'd1, 3'd0);
    expect_ev(p + LNG, 4'b0000, 4'b0000, 3'd0, 3'd1);
`ifdef KEY_REPEAT_EN
    expect_ev(p + LNG + REP, 4'b0000, 4'b0000, 3'd1, 3'd0);
`endif
    expect_ev(p + 30, 4'b1000, 4'b0000, 3'd4, 3'd0);
    expect_ev(p + 30 + LNG, 4'b0000, 4'b0000, 3'd0, 3'd4);
    expect_ev(p + 55, 4'b0000, 4'b1001, 3'd0, 3'd0);
    ticks(30);
    key_in = 4'b0110;
    ticks(25);
    chk("k03_owner_state", key_state, 4'b1001);
    key_in = 4'hF;
    ticks(12);

    // reset while key 1 is in the hold phase
    c = cyc;
    key_in = 4'b1101;
    expect_ev(c + 7, 4'b0010, 4'b0000, 3'd2, 3'd0);
    ticks(10);
    chk("pre_rst_state", key_state, 4'b0010);
    rst = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    ticks(2);
    rst = 1'b1;
    c = cyc;
    expect_ev(c + DEB + 3, 4'b0010, 4'b0000, 3'd2, 3'd0);
    expect_ev(c + 17, 4'b0000, 4'b0010, 3'd0, 3'd0);
    ticks(6);
    chk("rst_repress_early", key_state, 4'b0000);
    ticks(4);
    chk("rst_repress_state", key_state, 4'b0010);
    key_in = 4'hF;
    ticks(12);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
